// File: rtl/bcd_display_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_pkg
// Shared definitions for the seven-segment scan driver:
//   - seg_t        : 7-bit segment vector, bit order {g,f,e,d,c,b,a}
//   - SEG_0..SEG_9 : active-high patterns for BCD digits 0-9
//   - SEG_DASH     : pattern shown for non-BCD codes 10-15
//   - scan_state_t : scan controller states
// -----------------------------------------------------------------------------
package bcd_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to seven-segment decode. Codes 10-15 are not valid BCD
// and are shown as a dash so a broken upstream counter is visible.
// Ports:
//   bcd  in   4  BCD digit
//   seg  out  7  segments {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
// Time-multiplexed seven-segment driver. A prescaler divides clk into digit
// slots of PRESCALE cycles; each slot selects one digit, lowest first. The BCD
// and decimal-point inputs are snapshotted once per frame (on the tick that
// selects digit 0) so a frame never mixes values from two counter states.
//
// Parameters:
//   DIGITS    number of digits scanned (>= 2)
//   PRESCALE  clock cycles per digit slot (>= 2)
// Ports:
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous reset, active low
//   bcd_in       in   4*DIGITS  digit k = bcd_in[4k+3:4k], digit 0 rightmost
//   dp_in        in   DIGITS    decimal point request per digit
//   blank        in   1         forces all anodes off from the next edge
//   seg          out  7         segments {g,f,e,d,c,b,a}, active-high
//   dp           out  1         decimal point of current digit
//   an           out  DIGITS    one-hot anode select, bit k = digit k
//   frame_start  out  1         one-cycle pulse when digit 0 is selected
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (from the top,
//                          stopping at the first nonzero digit or first digit
//                          with dp set) have their anode held off. Digit 0 is
//                          always shown.
// -----------------------------------------------------------------------------
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    // ---------------------------------------------------------------- prescaler
    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PCNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    // ---------------------------------------------------------------- FSM
    scan_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          capture;   // this edge selects digit 0 and takes a snapshot

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    capture = 1'b1;
                end
            end
            ST_SCAN: begin
                if (tick) begin
                    capture = (idx_q == IDX_MAX);
                    idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- snapshot
    logic [4*DIGITS-1:0] snap_bcd;
    logic [DIGITS-1:0]   snap_dp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_bcd <= '0;
            snap_dp  <= '0;
        end else if (capture) begin
            snap_bcd <= bcd_in;
            snap_dp  <= dp_in;
        end
    end

    // On a capture edge the outputs must already reflect the new snapshot,
    // so the data source bypasses the snapshot register on that edge.
    logic [4*DIGITS-1:0] cur_bcd;
    logic [DIGITS-1:0]   cur_dp;
    logic [DIGITS-1:0]   cur_supp;   // digits whose anode is held off

    assign cur_bcd = capture ? bcd_in : snap_bcd;
    assign cur_dp  = capture ? dp_in  : snap_dp;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] supp_new;
    logic [DIGITS-1:0] supp_q;

    // Walk down from the top digit; a digit stays suppressed only while every
    // digit above it (and itself) is zero without a decimal point.
    always_comb begin
        logic run;
        supp_new = '0;
        run      = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run         = run & (bcd_in[4*k +: 4] == 4'd0) & ~dp_in[k];
            supp_new[k] = run;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         supp_q <= '0;
        else if (capture) supp_q <= supp_new;
    end

    assign cur_supp = capture ? supp_new : supp_q;
`else
    assign cur_supp = '0;
`endif

    // ---------------------------------------------------------------- decode
    logic [3:0] sel_bcd;
    logic [6:0] sel_seg;

    assign sel_bcd = cur_bcd[idx_d*4 +: 4];

    bcd_to_7seg u_dec (
        .bcd (sel_bcd),
        .seg (sel_seg)
    );

    // an is re-evaluated every cycle so blank takes effect (and releases) on
    // the next edge regardless of slot position; blank wins over a tick.
    logic [DIGITS-1:0] an_d;

    always_comb begin
        an_d = '0;
        if (state_d == ST_SCAN && !blank)
            an_d[idx_d] = ~cur_supp[idx_d];
    end

    // ---------------------------------------------------------------- outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg         <= '0;
            dp          <= 1'b0;
            an          <= '0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            frame_start <= capture;
            if (tick) begin
                seg <= sel_seg;
                dp  <= cur_dp[idx_d];
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (DIGITS=4, PRESCALE=4). Stimulus pushes
// expected {an,seg,dp,frame_start} tagged with the cycle at which they must be
// visible; a monitor on the falling edge pops and compares entries due now.
module tb_bcd_display_scan;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    bcd_display_scan #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .blank(blank),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    task automatic ex(input int c, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input logic f, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.fs = f; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: {an,seg,dp,fs} packed into one word per check
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL %s: expectation for cyc %0d not checked in time", e.name, e.cyc);
            end else begin
                chk(e.name, {3'b0, an, seg, dp, frame_start}, {3'b0, e.an, e.seg, e.dp, e.fs});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r2, b2;
        // ---------------- phase 1: reset release, scan, snapshot, dash, blank
        bcd_in = 16'h1234; dp_in = 4'b0000;
        base = 3 + 4;
        ex(2,          4'b0000, 7'h00, 0, 0, "reset_state");
        ex(base-1,     4'b0000, 7'h00, 0, 0, "idle_before_tick");
        ex(base,       4'b0001, 7'h66, 0, 1, "first_tick_d0");
        ex(base+1,     4'b0001, 7'h66, 0, 0, "fs_one_cycle");
        ex(base+4,     4'b0010, 7'h4F, 0, 0, "slot1_3");
        ex(base+8,     4'b0100, 7'h5B, 0, 0, "slot2_2");
        ex(base+12,    4'b1000, 7'h06, 0, 0, "slot3_1");
        ex(base+16,    4'b0001, 7'h66, 0, 1, "wrap_frame1");
        ex(base+20,    4'b0010, 7'h4F, 0, 0, "f1_slot1");
        ex(base+24,    4'b0100, 7'h5B, 0, 0, "f1_slot2");
        ex(base+27,    4'b0100, 7'h5B, 0, 0, "snap_hold_slot2");
        ex(base+28,    4'b1000, 7'h06, 0, 0, "snap_hold_slot3");
        ex(base+32,    4'b0001, 7'h7D, 0, 1, "new_snap_6");
        ex(base+36,    4'b0010, 7'h07, 0, 0, "new_snap_7");
        ex(base+40,    4'b0100, 7'h7F, 0, 0, "new_snap_8");
        ex(base+44,    4'b1000, 7'h6F, 0, 0, "new_snap_9");
        ex(base+48,    4'b0001, 7'h6D, 0, 1, "a5_d0");
        ex(base+52,    4'b0010, 7'h40, 0, 0, "a5_dash");
        ex(base+56,    4'b0100, 7'h3F, 1, 0, "a5_d2_dp");
        ex(base+60,    LZB ? 4'b0000 : 4'b1000, 7'h3F, 0, 0, "a5_d3");
        ex(base+64,    4'b0001, 7'h6D, 0, 1, "f4_d0");
        ex(base+68,    4'b0010, 7'h40, 0, 0, "f4_slot1");
        ex(base+69,    4'b0000, 7'h40, 0, 0, "blank_on");
        ex(base+72,    4'b0000, 7'h3F, 1, 0, "blank_wins_tick");
        ex(base+74,    4'b0000, 7'h3F, 1, 0, "blank_held");
        ex(base+75,    4'b0100, 7'h3F, 1, 0, "blank_release");
        ex(base+76,    LZB ? 4'b0000 : 4'b1000, 7'h3F, 0, 0, "after_blank_d3");

        goto(3);
        rst = 1'b1;
        goto(base+25);
        bcd_in = 16'h9876;
        goto(base+41);
        bcd_in = 16'h00A5; dp_in = 4'b0100;
        goto(base+68);
        blank = 1'b1;
        goto(base+74);
        blank = 1'b0;

        // ---------------- mid-scan asynchronous reset
        goto(base+80);
        #1;
        chk("pre_reset", {3'b0, an, seg, dp, frame_start}, {3'b0, 4'b0001, 7'h6D, 1'b0, 1'b1});
        rst = 1'b0;
        #1;
        chk("async_reset", {3'b0, an, seg, dp, frame_start}, 16'h0000);

        // ---------------- phase 2: release, leading-zero cases
        bcd_in = 16'h0007; dp_in = 4'b0000;
        r2 = base + 82;
        b2 = r2 + 4;
        ex(r2+1,  4'b0000, 7'h00, 0, 0, "r2_idle");
        ex(r2+3,  4'b0000, 7'h00, 0, 0, "r2_idle_last");
        ex(b2,    4'b0001, 7'h07, 0, 1, "r2_first_tick");
        ex(b2+4,  LZB ? 4'b0000 : 4'b0010, 7'h3F, 0, 0, "lz7_d1");
        ex(b2+8,  LZB ? 4'b0000 : 4'b0100, 7'h3F, 0, 0, "lz7_d2");
        ex(b2+12, LZB ? 4'b0000 : 4'b1000, 7'h3F, 0, 0, "lz7_d3");
        ex(b2+16, 4'b0001, 7'h3F, 0, 1, "zero_d0");
        ex(b2+20, LZB ? 4'b0000 : 4'b0010, 7'h3F, 0, 0, "zero_d1");
        ex(b2+32, 4'b0001, 7'h07, 0, 1, "lzdp_d0");
        ex(b2+36, 4'b0010, 7'h3F, 0, 0, "lzdp_d1");
        ex(b2+40, 4'b0100, 7'h3F, 1, 0, "lzdp_d2");
        ex(b2+44, LZB ? 4'b0000 : 4'b1000, 7'h3F, 0, 0, "lzdp_d3");

        goto(r2);
        rst = 1'b1;
        goto(b2+13);
        bcd_in = 16'h0000;
        goto(b2+21);
        bcd_in = 16'h0007; dp_in = 4'b0100;
        goto(b2+46);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL %s: expectation for cyc %0d never checked", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed seven-segment display driver, sitting directly downstream of the cascaded mod-10 counter chain. It consumes the BCD digits those counters produce, snapshots them once per scan frame to avoid tearing, and drives one digit at a time through anode-select and segment outputs.

## Interface
- DIGITS, 4: number of BCD digits scanned; at least 2.
- PRESCALE, 1000: clock cycles per digit slot; at least 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- bcd_in  input  4*DIGITS  BCD digits; digit k = bcd_in[4k+3:4k]; digit 0 is least significant (rightmost).
- dp_in  input  DIGITS  decimal point request per digit.
- blank  input  1  forces all anodes off while high.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  output  1  decimal point of the current digit, active-high.
- an  output  DIGITS  one-hot anode select, active-high; bit k drives digit k.
- frame_start  output  1  one-cycle pulse when a new frame begins (digit 0 selected, snapshot taken).

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` = (pcnt == PRESCALE-1).
- FSM states:
  - IDLE: entered on reset; outputs off.
  - SCAN: entered from IDLE on the first tick.
- Digit index `idx`, 0..DIGITS-1:
  - IDLE->SCAN: idx = 0.
  - In SCAN, on each tick: idx = idx+1, wrapping DIGITS-1 -> 0.
- Snapshot of bcd_in and dp_in is captured on every tick that selects idx 0 (the first tick, and every wrap). frame_start pulses on that same edge.
- Between snapshots, bcd_in/dp_in changes have no visible effect.
- Decode of a snapshot digit:
  - 0-9 patterns: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F.
  - Codes 10-15: 0x40 (dash).
- seg, dp and an are registers, loaded on the tick edge with the values for the newly selected digit:
  - seg = decode(snapshot digit), dp = snapshot dp bit, an = one-hot(idx).
- blank:
  - Sampled every cycle. While high, an = 0 from the next edge on.
  - The prescaler, idx and snapshot keep running while blank is high.
  - On deassert, an = one-hot(current idx) from the next edge on.

## Timing
- Reset values: pcnt=0, idx=0, state=IDLE, snapshot=0, seg=0, dp=0, an=0, frame_start=0.
- Reset asserted mid-frame: all of the above immediately, independent of clk.
- First tick: the PRESCALE-th rising edge after rst deasserts. On that edge an=0...01 and frame_start=1.
- Each digit slot lasts exactly PRESCALE cycles.
- Full frame = DIGITS*PRESCALE cycles. frame_start period is the same.
- No added latency: the value on the outputs after a tick edge reflects the snapshot taken on that edge.
- blank and tick on the same edge: blank wins (an=0). idx still advances and seg/dp still load.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: scanning from digit DIGITS-1 downward, snapshot digits equal to 0 have their an slot forced 0.
  - Suppression stops at the first nonzero digit or the first digit whose dp bit is set.
  - Digit 0 is never suppressed.
  - Evaluated from the snapshot, so the suppressed set is constant within a frame.
- Undefined: every digit is displayed, including leading zeros.

## Structure
- Shared package `bcd_display_pkg`:
  - The ten segment-pattern constants and SEG_DASH = 7'h40.
  - A segment-vector typedef (7 bits).
- Sub-module `bcd_to_7seg`: combinational 4-bit BCD to 7-bit segment decode including the dash case, instantiated once on the selected snapshot digit.
- Prescaler, FSM, snapshot and output registers live in the top module.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4.
- Reset: rst=0 mid-scan -> an=0000, seg=0, dp=0, frame_start=0 immediately. Release -> 4th edge gives an=0001 and a frame_start pulse.
- bcd_in=16'h1234, dp_in=0 -> over successive slots: seg=0x66/an=0001, 0x4F/0010, 0x5B/0100, 0x06/1000; an wraps to 0001 after 16 cycles.
- Snapshot: bcd_in changes 16'h1234 -> 16'h9876 during slot 2 -> remaining slots still show 2, 1; the next frame shows 6 (0x7D) on an=0001 with frame_start=1.
- bcd_in=16'h00A5, dp_in=4'b0100 -> digit 1 seg=0x40; digit 2 seg=0x3F with dp=1.
- blank=1 for 6 cycles starting in slot 1 -> an=0000 from the next edge. On release, an matches the idx advanced in the meantime (0100 or 1000 as appropriate).
- With LEADING_ZERO_BLANK_EN defined:
  - 16'h0007 -> only slot 0 lit (an=0001); slots 1-3 an=0000.
  - 16'h0000 -> digit 0 shows 0x3F.
  - 16'h0007 with dp_in=4'b0100 -> digits 0-2 lit.
